dlcount_bcd: RTL and testbench

Multi-digit BCD event counter that consumes the slow square wave produced by the delay-clock divider stage and advances once per rising edge of that wave. It runs entirely in the fast system clock domain, treating the slow wave as a data input (synchronised and edge-detected), never as a clock. Its output feeds the display stage with packed BCD digits plus wrap and step pulses.

---
 rtl/dlcount_bcd_if.sv | 41 ++++
 rtl/dlcount_bcd.sv | 141 ++++++++++++++
 tb/tb_dlcount_bcd.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dlcount_bcd_if.sv
// Control/status bundle between the counter control source and dlcount_bcd.
// The down input exists only when DLCOUNT_DOWN_EN is defined.
interface dlcount_bcd_if #(
   parameter int DIGITS = 4
);
   logic                  start;
   logic                  stop;
   logic                  clear;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
`ifdef DLCOUNT_DOWN_EN
   logic                  down;
`endif
   logic [4*DIGITS-1:0]   count;
   logic                  tick;
   logic                  carry;
   logic                  running;
   logic [1:0]            state;

`ifdef DLCOUNT_DOWN_EN
   modport master (
      output start, stop, clear, load, load_val, down,
      input  count, tick, carry, running, state
   );

   modport slave (
      input  start, stop, clear, load, load_val, down,
      output count, tick, carry, running, state
   );
`else
   modport master (
      output start, stop, clear, load, load_val,
      input  count, tick, carry, running, state
   );

   modport slave (
      input  start, stop, clear, load, load_val,
      output count, tick, carry, running, state
   );
`endif
endinterface

// File: rtl/dlcount_bcd.sv
// Multi-digit BCD event counter stepped by rising edges of the slow dlclk wave,
// sampled in the clk domain. Define DLCOUNT_DOWN_EN to add the down-count direction.
module dlcount_bcd #(
   parameter int DIGITS = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         dlclk,
   dlcount_bcd_if.slave bus
);
   localparam int W = 4 * DIGITS;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic           sync1;
   logic           sync2;
   logic           edge_q;
   logic           rise;
   logic           tick_q;
   logic           carry_q;
   logic [1:0]     state_q;
   logic [1:0]     state_d;
   logic [W-1:0]   count_q;
   logic [W-1:0]   load_clamped;
   logic [W-1:0]   inc_val;
   logic [W-1:0]   step_val;
   logic           up_cy;
   logic           step_wrap;
   logic           step_en;
`ifdef DLCOUNT_DOWN_EN
   logic [W-1:0]   dec_val;
   logic           dn_cy;
`endif

   // dlclk is treated as plain data: two flops for metastability, one for edge history
   assign rise    = sync2 & ~edge_q;
   assign step_en = (state_q == S_RUN) & rise;

   always_comb begin
      state_d = state_q;
      if (bus.clear) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (bus.start)               state_d = S_RUN;
            S_RUN:   if (bus.stop)                state_d = S_HOLD;
            S_HOLD:  if (bus.start && !bus.stop)  state_d = S_RUN;
            default:                              state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      load_clamped = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bus.load_val[4*i +: 4] > 4'd9)
            load_clamped[4*i +: 4] = 4'd9;
         else
            load_clamped[4*i +: 4] = bus.load_val[4*i +: 4];
      end
   end

   // Ripple increment: up_cy survives the loop only when every digit was 9
   always_comb begin
      inc_val = count_q;
      up_cy   = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (up_cy) begin
            if (count_q[4*i +: 4] == 4'd9) begin
               inc_val[4*i +: 4] = 4'd0;
            end else begin
               inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
               up_cy             = 1'b0;
            end
         end
      end
   end

`ifdef DLCOUNT_DOWN_EN
   always_comb begin
      dec_val = count_q;
      dn_cy   = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (dn_cy) begin
            if (count_q[4*i +: 4] == 4'd0) begin
               dec_val[4*i +: 4] = 4'd9;
            end else begin
               dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
               dn_cy             = 1'b0;
            end
         end
      end
   end

   always_comb begin
      step_val  = bus.down ? dec_val : inc_val;
      step_wrap = bus.down ? dn_cy   : up_cy;
   end
`else
   always_comb begin
      step_val  = inc_val;
      step_wrap = up_cy;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         edge_q  <= 1'b0;
         tick_q  <= 1'b0;
         carry_q <= 1'b0;
         count_q <= '0;
         state_q <= S_IDLE;
      end else begin
         sync1   <= dlclk;
         sync2   <= sync1;
         edge_q  <= sync2;
         tick_q  <= rise;
         state_q <= state_d;
         carry_q <= 1'b0;
         // clear and load both override a step landing in the same cycle
         if (bus.clear) begin
            count_q <= '0;
         end else if (bus.load) begin
            count_q <= load_clamped;
         end else if (step_en) begin
            count_q <= step_val;
            carry_q <= step_wrap;
         end
      end
   end

   assign bus.count   = count_q;
   assign bus.tick    = tick_q;
   assign bus.carry   = carry_q;
   assign bus.running = (state_q == S_RUN);
   assign bus.state   = state_q;
endmodule

// File: tb/tb_dlcount_bcd.sv
// Self-checking bench for dlcount_bcd: load-clamp vector table, hand sequences for
// latency/wrap/priority/hold corners, then random stimulus against a decimal model.
module tb_dlcount_bcd;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 9999;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;

  typedef struct {
    logic         rst;
    logic         start;
    logic         stop;
    logic         clear;
    logic         load;
    logic         down;
    logic         dl;
    logic [W-1:0] load_val;
  } in_t;

  typedef struct {
    logic [W-1:0] lv;
    logic [W-1:0] exp;
  } load_vec_t;

  logic clk = 1'b0;
  logic rst;
  logic dlclk;

  always #5 clk = ~clk;

  dlcount_bcd_if #(.DIGITS(DIGITS)) bus ();

  dlcount_bcd #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .dlclk (dlclk),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int tick_seen = 0;
  int carry_seen = 0;

  // reference model: decimal value, control state, dlclk sample history
  in_t          cur;
  int           m_val = 0;
  int           m_st  = M_IDLE;
  bit           hist[$] = '{1'b0, 1'b0, 1'b0};
  logic [W-1:0] exp_q[$];
  load_vec_t    tbl[6];

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [W-1:0] lv);
    int v;
    int d;
    int p;
    v = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 9;
      v = v + d * p;
      p = p * 10;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // one clk cycle: drive cur, advance the model, sample #1 after the edge
  task automatic step();
    bit   e_tick;
    bit   e_carry;
    bit   up;
    logic [W-1:0] e_cnt;
    rst          = cur.rst;
    dlclk        = cur.dl;
    bus.start    = cur.start;
    bus.stop     = cur.stop;
    bus.clear    = cur.clear;
    bus.load     = cur.load;
    bus.load_val = cur.load_val;
`ifdef DLCOUNT_DOWN_EN
    bus.down     = cur.down;
    up           = !cur.down;
`else
    up           = 1'b1;
`endif
    e_carry = 1'b0;
    e_tick  = 1'b0;
    if (cur.rst) begin
      hist  = '{1'b0, 1'b0, 1'b0};
      m_val = 0;
      m_st  = M_IDLE;
    end else begin
      // a rise seen by the synchroniser two samples back, low three samples back
      e_tick = hist[1] && !hist[0];
      hist.push_back(cur.dl);
      void'(hist.pop_front());
      if (cur.clear) begin
        m_val = 0;
      end else if (cur.load) begin
        m_val = clamp_val(cur.load_val);
      end else if (m_st == M_RUN && e_tick) begin
        if (up) begin
          e_carry = (m_val == MAXV);
          m_val   = (m_val + 1) % (MAXV + 1);
        end else begin
          e_carry = (m_val == 0);
          m_val   = (m_val == 0) ? MAXV : m_val - 1;
        end
      end
      if (cur.clear) m_st = M_IDLE;
      else if (m_st == M_IDLE && cur.start) m_st = M_RUN;
      else if (m_st == M_RUN && cur.stop) m_st = M_HOLD;
      else if (m_st == M_HOLD && cur.start && !cur.stop) m_st = M_RUN;
    end
    exp_q.push_back(to_bcd(m_val));
    @(posedge clk);
    #1;
    e_cnt = exp_q.pop_front();
    chk("count", 32'(bus.count), 32'(e_cnt));
    chk("tick", 32'(bus.tick), 32'(e_tick));
    chk("carry", 32'(bus.carry), 32'(e_carry));
    chk("running", 32'(bus.running), 32'(m_st == M_RUN));
    tick_seen  += int'(bus.tick);
    carry_seen += int'(bus.carry);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rise_edge();
    cur.dl = 1'b1;
    cycles(3);
    cur.dl = 1'b0;
    cycles(3);
  endtask

  initial begin
    int hold;
    tbl[0] = '{lv: 16'h12F5, exp: 16'h1295};
    tbl[1] = '{lv: 16'hFFFF, exp: 16'h9999};
    tbl[2] = '{lv: 16'hA0B1, exp: 16'h9091};
    tbl[3] = '{lv: 16'h0000, exp: 16'h0000};
    tbl[4] = '{lv: 16'h9999, exp: 16'h9999};
    tbl[5] = '{lv: 16'h3C4D, exp: 16'h3949};

    cur = '{rst: 1'b1, start: 1'b0, stop: 1'b0, clear: 1'b0, load: 1'b0,
            down: 1'b0, dl: 1'b0, load_val: '0};

    // reset, then dlclk toggling with no start
    cycles(2);
    cur.rst = 1'b0;
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_running", 32'(bus.running), 32'h0);
    chk("rst_tick", 32'(bus.tick), 32'h0);
    chk("rst_carry", 32'(bus.carry), 32'h0);
    tick_seen = 0;
    carry_seen = 0;
    for (int i = 0; i < 4; i++) rise_edge();
    chk("idle_ticks", 32'(tick_seen), 32'd4);
    chk("idle_carry", 32'(carry_seen), 32'd0);
    chk("idle_count", 32'(bus.count), 32'h0);

    // dlclk already high when reset releases: one tick three cycles later
    cur.dl  = 1'b1;
    cur.rst = 1'b1;
    cycles(2);
    cur.rst = 1'b0;
    cycles(2);
    chk("rel_tick_early", 32'(bus.tick), 32'h0);
    step();
    chk("rel_tick", 32'(bus.tick), 32'h1);
    step();
    chk("rel_tick_once", 32'(bus.tick), 32'h0);
    cur.dl = 1'b0;
    cycles(3);

    // basic count with explicit first-edge latency
    cur.start = 1'b1;
    step();
    cur.start = 1'b0;
    chk("start_running", 32'(bus.running), 32'h1);
    cur.dl = 1'b1;
    cycles(2);
    chk("lat_tick_early", 32'(bus.tick), 32'h0);
    chk("lat_count_early", 32'(bus.count), 32'h0);
    step();
    chk("lat_tick", 32'(bus.tick), 32'h1);
    chk("lat_count", 32'(bus.count), 32'h0001);
    cur.dl = 1'b0;
    cycles(3);
    for (int i = 0; i < 11; i++) rise_edge();
    chk("basic_count", 32'(bus.count), 32'h0012);

    // wrap 9998 -> 9999 -> 0000
    cur.load = 1'b1;
    cur.load_val = 16'h9998;
    step();
    cur.load = 1'b0;
    rise_edge();
    chk("wrap_9999", 32'(bus.count), 32'h9999);
    carry_seen = 0;
    cur.dl = 1'b1;
    cycles(3);
    chk("wrap_count", 32'(bus.count), 32'h0000);
    chk("wrap_carry", 32'(bus.carry), 32'h1);
    cur.dl = 1'b0;
    cycles(3);
    chk("wrap_carry_once", 32'(carry_seen), 32'd1);

    // load on a tick cycle in RUN: clamped load wins, no step
    cur.dl = 1'b1;
    cycles(2);
    cur.load = 1'b1;
    cur.load_val = 16'h12F5;
    step();
    cur.load = 1'b0;
    chk("prio_tick", 32'(bus.tick), 32'h1);
    chk("prio_load", 32'(bus.count), 32'h1295);
    cycles(2);
    cur.dl = 1'b0;
    cycles(3);
    chk("prio_nostep", 32'(bus.count), 32'h1295);
    cur.clear = 1'b1;
    cur.start = 1'b1;
    step();
    cur.clear = 1'b0;
    chk("clr_count", 32'(bus.count), 32'h0);
    chk("clr_idle", 32'(bus.running), 32'h0);
    step();
    cur.start = 1'b0;
    chk("clr_restart", 32'(bus.running), 32'h1);

    // start+stop together -> HOLD; ticks continue, count frozen
    for (int i = 0; i < 3; i++) rise_edge();
    cur.start = 1'b1;
    cur.stop  = 1'b1;
    step();
    chk("hold_entry", 32'(bus.running), 32'h0);
    tick_seen = 0;
    for (int i = 0; i < 5; i++) rise_edge();
    chk("hold_count", 32'(bus.count), 32'h0003);
    chk("hold_ticks", 32'(tick_seen), 32'd5);
    cur.stop = 1'b0;
    step();
    cur.start = 1'b0;
    chk("hold_resume", 32'(bus.running), 32'h1);
    rise_edge();
    rise_edge();
    chk("resume_count", 32'(bus.count), 32'h0005);

    // reset mid-count loses the count without a carry
    carry_seen = 0;
    cur.rst = 1'b1;
    step();
    cur.rst = 1'b0;
    step();
    chk("midrst_count", 32'(bus.count), 32'h0);
    chk("midrst_running", 32'(bus.running), 32'h0);
    chk("midrst_carry", 32'(carry_seen), 32'd0);

    // load clamp vector table
    for (int i = 0; i < 6; i++) begin
      cur.load = 1'b1;
      cur.load_val = tbl[i].lv;
      step();
      chk($sformatf("clamp_%0d", i), 32'(bus.count), 32'(tbl[i].exp));
    end
    cur.load = 1'b0;

`ifdef DLCOUNT_DOWN_EN
    cur.start = 1'b1;
    step();
    cur.start = 1'b0;
    cur.load = 1'b1;
    cur.load_val = 16'h0001;
    step();
    cur.load = 1'b0;
    cur.down = 1'b1;
    rise_edge();
    chk("down_0000", 32'(bus.count), 32'h0000);
    carry_seen = 0;
    rise_edge();
    chk("down_9999", 32'(bus.count), 32'h9999);
    chk("down_carry", 32'(carry_seen), 32'd1);
    cur.down = 1'b0;
`endif

    // random stimulus against the model
    hold = 0;
    for (int n = 0; n < 4000; n++) begin
      cur.rst   = ($urandom_range(0, 399) == 0);
      cur.start = ($urandom_range(0, 7) == 0);
      cur.stop  = ($urandom_range(0, 19) == 0);
      cur.clear = ($urandom_range(0, 79) == 0);
      cur.load  = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 2))
        0:       cur.load_val = 16'h9997;
        1:       cur.load_val = 16'h0002;
        default: cur.load_val = W'($urandom);
      endcase
      cur.down = 1'($urandom_range(0, 1));
      if (hold == 0) begin
        cur.dl = ~cur.dl;
        hold   = $urandom_range(1, 4);
      end else begin
        hold--;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
